// File: rtl/ttc_trigger_receiver.sv
// TTC L1A / broadcast decoder feeding the channel acquisition controller trigger port.
// Optional build macro TTC_ECR_EN: broadcast code 4'hF acts as an event counter reset.
`default_nettype none

module ttc_trigger_receiver #(
    parameter int unsigned TYPE_WINDOW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ttc_l1a,
    input  logic        ttc_brdcst_stb,
    input  logic [5:0]  ttc_brdcst,
    input  logic        acq_ready,
    output logic        trigger,
    output logic [4:0]  trig_type,
    output logic [23:0] trig_num,
    output logic [15:0] drop_cnt,
    output logic [15:0] orphan_cnt,
    output logic [15:0] timeout_cnt,
    output logic [2:0]  state
);

    localparam int unsigned WIN_W = (TYPE_WINDOW < 2) ? 1 : $clog2(TYPE_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TYPE_WINDOW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ARMED = 3'b010,
        S_ISSUE = 3'b100
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        armed_type_q, armed_type_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [23:0]       l1a_cnt_q, l1a_cnt_d;
    logic [4:0]        trig_type_q, trig_type_d;
    logic [23:0]       trig_num_q, trig_num_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [15:0]       orphan_cnt_q, orphan_cnt_d;
    logic [15:0]       timeout_cnt_q, timeout_cnt_d;

    logic [3:0] code;
    logic       type_stb;
    logic       ecr_stb;
    logic       unused_brdcst_lsbs;

    assign code               = ttc_brdcst[5:2];
    assign unused_brdcst_lsbs = ^ttc_brdcst[1:0];
    assign type_stb           = ttc_brdcst_stb && (code != 4'h0) && (code != 4'hF);

`ifdef TTC_ECR_EN
    assign ecr_stb = ttc_brdcst_stb && (code == 4'hF);
`else
    assign ecr_stb = 1'b0;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        armed_type_d  = armed_type_q;
        win_cnt_d     = win_cnt_q;
        trig_type_d   = trig_type_q;
        trig_num_d    = trig_num_q;
        drop_cnt_d    = drop_cnt_q;
        orphan_cnt_d  = orphan_cnt_q;
        timeout_cnt_d = timeout_cnt_q;

        // Every L1A is numbered; an ECR in the same cycle wins over the increment.
        l1a_cnt_d = l1a_cnt_q;
        if (ecr_stb)
            l1a_cnt_d = '0;
        else if (ttc_l1a)
            l1a_cnt_d = l1a_cnt_q + 24'd1;

        unique case (state_q)
            S_IDLE: begin
                if (ttc_l1a)
                    orphan_cnt_d = sat_inc(orphan_cnt_q);
                if (type_stb) begin
                    armed_type_d = code;
                    win_cnt_d    = '0;
                    state_d      = S_ARMED;
                end
            end

            S_ARMED: begin
                // An L1A consumes the armed type; a broadcast in the same cycle is discarded.
                if (ttc_l1a) begin
                    if (acq_ready) begin
                        trig_type_d = {1'b0, armed_type_q};
                        trig_num_d  = l1a_cnt_q + 24'd1;
                        state_d     = S_ISSUE;
                    end else begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = S_IDLE;
                    end
                end else if (type_stb) begin
                    armed_type_d = code;
                    win_cnt_d    = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    timeout_cnt_d = sat_inc(timeout_cnt_q);
                    state_d       = S_IDLE;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end

            S_ISSUE: begin
                if (ttc_l1a)
                    orphan_cnt_d = sat_inc(orphan_cnt_q);
                if (type_stb) begin
                    armed_type_d = code;
                    win_cnt_d    = '0;
                    state_d      = S_ARMED;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            armed_type_q  <= '0;
            win_cnt_q     <= '0;
            l1a_cnt_q     <= '0;
            trig_type_q   <= '0;
            trig_num_q    <= '0;
            drop_cnt_q    <= '0;
            orphan_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            armed_type_q  <= armed_type_d;
            win_cnt_q     <= win_cnt_d;
            l1a_cnt_q     <= l1a_cnt_d;
            trig_type_q   <= trig_type_d;
            trig_num_q    <= trig_num_d;
            drop_cnt_q    <= drop_cnt_d;
            orphan_cnt_q  <= orphan_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Reset during the ISSUE cycle suppresses the pending pulse immediately.
    assign trigger     = (state_q == S_ISSUE) && !reset;
    assign trig_type   = trig_type_q;
    assign trig_num    = trig_num_q;
    assign drop_cnt    = drop_cnt_q;
    assign orphan_cnt  = orphan_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ttc_trigger_receiver.sv
// Directed bench for ttc_trigger_receiver: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps

module tb_ttc_trigger_receiver;

    localparam int TW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ttc_l1a = 1'b0;
    logic        ttc_brdcst_stb = 1'b0;
    logic [5:0]  ttc_brdcst = 6'd0;
    logic        acq_ready = 1'b1;
    logic        trigger;
    logic [4:0]  trig_type;
    logic [23:0] trig_num;
    logic [15:0] drop_cnt, orphan_cnt, timeout_cnt;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    ttc_trigger_receiver #(.TYPE_WINDOW(TW)) dut (
        .clk(clk), .reset(reset), .ttc_l1a(ttc_l1a), .ttc_brdcst_stb(ttc_brdcst_stb),
        .ttc_brdcst(ttc_brdcst), .acq_ready(acq_ready), .trigger(trigger),
        .trig_type(trig_type), .trig_num(trig_num), .drop_cnt(drop_cnt),
        .orphan_cnt(orphan_cnt), .timeout_cnt(timeout_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stb; int code; int l1a; int rdy;
        int trg; int typ; int num; int st; int drop; int orph; int tmo;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(int stb, int code, int l1a, int rdy, int trg, int typ,
                                int num, int st, int drop, int orph, int tmo);
        vec_t v;
        v.stb = stb; v.code = code; v.l1a = l1a; v.rdy = rdy;
        v.trg = trg; v.typ = typ; v.num = num; v.st = st;
        v.drop = drop; v.orph = orph; v.tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int trg, input int typ, input int num,
                           input int st, input int drop, input int orph, input int tmo);
        chk({tag, "_trigger"}, 32'(trigger), trg);
        chk({tag, "_type"},    32'(trig_type), typ);
        chk({tag, "_num"},     32'(trig_num), num);
        chk({tag, "_state"},   32'(state), st);
        chk({tag, "_drop"},    32'(drop_cnt), drop);
        chk({tag, "_orphan"},  32'(orphan_cnt), orph);
        chk({tag, "_timeout"}, 32'(timeout_cnt), tmo);
    endtask

    // Drive one cycle of inputs, sample 1ns after the edge, then return inputs to quiet.
    task automatic step(input int stb, input int code, input int l1a, input int rdy);
        logic [31:0] c;
        c = 32'(code);
        @(negedge clk);
        ttc_brdcst_stb = (stb != 0);
        ttc_brdcst     = {c[3:0], 2'b10};
        ttc_l1a        = (l1a != 0);
        acq_ready      = (rdy != 0);
        @(posedge clk);
        #1;
        ttc_brdcst_stb = 1'b0;
        ttc_brdcst     = 6'd0;
        ttc_l1a        = 1'b0;
        acq_ready      = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //           stb code l1a rdy | trg typ num st drop orph tmo
        vt[0]  = mk(0, 4'h0, 0, 1,   0, 0,  0, 1, 0, 0, 0);
        vt[1]  = mk(1, 4'h1, 0, 1,   0, 0,  0, 2, 0, 0, 0);
        vt[2]  = mk(0, 4'h0, 0, 1,   0, 0,  0, 2, 0, 0, 0);
        vt[3]  = mk(0, 4'h0, 0, 1,   0, 0,  0, 2, 0, 0, 0);
        vt[4]  = mk(0, 4'h0, 1, 1,   1, 1,  1, 4, 0, 0, 0);
        vt[5]  = mk(0, 4'h0, 0, 1,   0, 1,  1, 1, 0, 0, 0);
        vt[6]  = mk(1, 4'h2, 0, 1,   0, 1,  1, 2, 0, 0, 0);
        vt[7]  = mk(0, 4'h0, 1, 0,   0, 1,  1, 1, 1, 0, 0);
        vt[8]  = mk(1, 4'h2, 0, 1,   0, 1,  1, 2, 1, 0, 0);
        vt[9]  = mk(0, 4'h0, 1, 1,   1, 2,  3, 4, 1, 0, 0);
        vt[10] = mk(1, 4'h5, 1, 1,   0, 2,  3, 2, 1, 1, 0);
        vt[11] = mk(1, 4'h7, 1, 1,   1, 5,  5, 4, 1, 1, 0);
        vt[12] = mk(0, 4'h0, 1, 1,   0, 5,  5, 1, 1, 2, 0);
        vt[13] = mk(1, 4'hE, 1, 1,   0, 5,  5, 2, 1, 3, 0);
        vt[14] = mk(0, 4'h0, 1, 1,   1, 14, 8, 4, 1, 3, 0);
        vt[15] = mk(1, 4'h0, 0, 1,   0, 14, 8, 1, 1, 3, 0);
        vt[16] = mk(1, 4'h3, 0, 1,   0, 14, 8, 2, 1, 3, 0);
        vt[17] = mk(1, 4'h4, 0, 1,   0, 14, 8, 2, 1, 3, 0);
        vt[18] = mk(0, 4'h0, 1, 1,   1, 4,  9, 4, 1, 3, 0);
        vt[19] = mk(0, 4'h0, 0, 1,   0, 4,  9, 1, 1, 3, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(vt[i].stb, vt[i].code, vt[i].l1a, vt[i].rdy);
            chk_all($sformatf("v%0d", i), vt[i].trg, vt[i].typ, vt[i].num,
                    vt[i].st, vt[i].drop, vt[i].orph, vt[i].tmo);
        end

        // Armed window expiry: still armed after TW-1 quiet cycles, idle after TW.
        step(1, 4'h3, 0, 1);
        repeat (TW - 1) idle();
        chk("win_last_armed", 32'(state), 2);
        idle();
        chk("win_expired_state", 32'(state), 1);
        chk("win_expired_cnt", 32'(timeout_cnt), 1);
        step(0, 0, 1, 1);
        chk("post_timeout_orphan", 32'(orphan_cnt), 4);
        chk("post_timeout_no_trig", 32'(trigger), 0);

        // L1A on the final armed cycle is still accepted.
        step(1, 4'h8, 0, 1);
        repeat (TW - 1) idle();
        step(0, 0, 1, 1);
        chk("win_edge_trigger", 32'(trigger), 1);
        chk("win_edge_type", 32'(trig_type), 8);
        chk("win_edge_num", 32'(trig_num), 11);
        chk("win_edge_timeout", 32'(timeout_cnt), 1);
        idle();

        // Trigger number wraps from FFFFFF to 0.
        @(negedge clk);
        force dut.l1a_cnt_q = 24'hFFFFFF;
        @(negedge clk);
        release dut.l1a_cnt_q;
        step(1, 4'h9, 0, 1);
        step(0, 0, 1, 1);
        chk("wrap_num", 32'(trig_num), 0);
        chk("wrap_type", 32'(trig_type), 9);
        idle();
        step(1, 4'hA, 0, 1);
        step(0, 0, 1, 1);
        chk("wrap_next_num", 32'(trig_num), 1);
        idle();

        // Orphan counter saturates.
        @(negedge clk);
        force dut.orphan_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.orphan_cnt_q;
        step(0, 0, 1, 1);
        chk("sat_reach", 32'(orphan_cnt), 32'hFFFF);
        step(0, 0, 1, 1);
        chk("sat_hold", 32'(orphan_cnt), 32'hFFFF);

        // Reset in the ISSUE cycle: no pulse, everything back to reset values.
        step(1, 4'h6, 0, 1);
        @(negedge clk);
        ttc_l1a = 1'b1;
        @(posedge clk);
        #1;
        ttc_l1a = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_issue_no_pulse", 32'(trigger), 0);
        @(posedge clk);
        #1;
        chk_all("rst_issue", 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b0;

        // Event counter reset after five triggers.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 4'h1, 0, 1);
            step(0, 0, 1, 1);
            idle();
        end
        chk("ecr_pre_num", 32'(trig_num), 5);
        step(1, 4'hF, 0, 1);
        chk("ecr_idle_state", 32'(state), 1);
        step(1, 4'h4, 0, 1);
        step(1, 4'hF, 0, 1);
        chk("ecr_keeps_armed", 32'(state), 2);
        step(0, 0, 1, 1);
        chk("ecr_keeps_type", 32'(trig_type), 4);
`ifdef TTC_ECR_EN
        chk("ecr_num", 32'(trig_num), 1);
`else
        chk("ecr_num", 32'(trig_num), 6);
`endif
        idle();
        step(1, 4'h2, 0, 1);
        step(1, 4'hF, 1, 1);
`ifdef TTC_ECR_EN
        chk("ecr_same_cycle_num", 32'(trig_num), 2);
`else
        chk("ecr_same_cycle_num", 32'(trig_num), 7);
`endif
        idle();
        step(1, 4'h3, 0, 1);
        step(0, 0, 1, 1);
`ifdef TTC_ECR_EN
        chk("ecr_after_num", 32'(trig_num), 1);
`else
        chk("ecr_after_num", 32'(trig_num), 8);
`endif
        chk("ecr_after_type", 32'(trig_type), 3);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
